// File: rtl/led_frame_sequencer.sv
// Sequences the LED capture shift register: gap detection, bit gating, passthrough confirmation, frame bookkeeping.
// One cycle from input bit to o_valid; no backpressure, and bits arriving outside CAPTURE are never forwarded.
module led_frame_sequencer #(
  parameter int RESET_CYCLES = 2500,
  parameter int LED_BITS     = 24,
  parameter int PT_TIMEOUT   = 4,
  parameter int CNT_W        = 16
) (
  input  logic             i_clk,
  input  logic             i_reset_n,
  input  logic             i_bit_valid,
  input  logic             i_bit,
  input  logic             i_line_idle,
  input  logic             i_passthru_en,
  output logic             o_treset,
  output logic             o_valid,
  output logic             o_valid_strobe,
  output logic             o_decode_bit,
  output logic             o_latch,
  output logic             o_frame_active,
  output logic [4:0]       o_bit_count,
  output logic [CNT_W-1:0] o_fwd_count,
  output logic [CNT_W-1:0] o_frame_count,
  output logic             o_error
);

  localparam int IW = $clog2(RESET_CYCLES + 1);
  localparam int PW = $clog2(PT_TIMEOUT + 1);
  localparam logic [IW-1:0] IDLE_MAX = IW'(RESET_CYCLES);
  localparam logic [PW-1:0] PT_LAST  = PW'(PT_TIMEOUT - 1);
  localparam logic [4:0]    LB       = 5'(LED_BITS);
  localparam logic [4:0]    LB_LAST  = 5'(LED_BITS - 1);

  typedef enum logic [1:0] {WAIT_RESET, CAPTURE, WAIT_PT, FORWARD} state_t;

  state_t           state_q;
  logic [IW-1:0]    idle_cnt_q, idle_cnt_d;
  logic [PW-1:0]    pt_cnt_q;
  logic [4:0]       bit_count_q;
  logic [CNT_W-1:0] fwd_count_q, fwd_inc, frame_count_q;
  logic             treset_q, valid_q, decode_q, latch_q, error_q;
  logic             gap;

  always_comb begin
    idle_cnt_d = idle_cnt_q;
    if (i_bit_valid || !i_line_idle) idle_cnt_d = '0;
    else if (idle_cnt_q != IDLE_MAX)  idle_cnt_d = idle_cnt_q + 1'b1;
  end

  // Gap fires only on the step into saturation, so one long idle stretch yields one event.
  assign gap     = (idle_cnt_q != IDLE_MAX) && (idle_cnt_d == IDLE_MAX);
  assign fwd_inc = (&fwd_count_q) ? fwd_count_q : fwd_count_q + 1'b1;

  always_ff @(posedge i_clk or negedge i_reset_n) begin
    if (!i_reset_n) idle_cnt_q <= '0;
    else            idle_cnt_q <= idle_cnt_d;
  end

  always_ff @(posedge i_clk or negedge i_reset_n) begin
    if (!i_reset_n) begin
      state_q       <= WAIT_RESET;
      pt_cnt_q      <= '0;
      bit_count_q   <= '0;
      fwd_count_q   <= '0;
      frame_count_q <= '0;
      treset_q      <= 1'b0;
      valid_q       <= 1'b0;
      decode_q      <= 1'b0;
      latch_q       <= 1'b0;
      error_q       <= 1'b0;
    end else begin
      treset_q <= gap;
      valid_q  <= 1'b0;
      decode_q <= 1'b0;
      latch_q  <= 1'b0;
      error_q  <= 1'b0;
      case (state_q)
        WAIT_RESET: begin
          if (gap) begin
            state_q     <= CAPTURE;
            bit_count_q <= '0;
            fwd_count_q <= '0;
          end
        end
        CAPTURE: begin
          if (gap) begin
            // A partial frame is an error; an empty one simply re-arms.
            if (bit_count_q != 5'd0) error_q <= 1'b1;
            bit_count_q <= '0;
            fwd_count_q <= '0;
          end else if (i_bit_valid && (bit_count_q < LB)) begin
            valid_q     <= 1'b1;
            decode_q    <= i_bit;
            bit_count_q <= bit_count_q + 1'b1;
            if (bit_count_q == LB_LAST) begin
              state_q  <= WAIT_PT;
              pt_cnt_q <= '0;
            end
          end
        end
        WAIT_PT: begin
          if (gap) begin
            error_q     <= 1'b1;
            state_q     <= CAPTURE;
            bit_count_q <= '0;
            fwd_count_q <= '0;
          end else begin
            if (i_bit_valid) fwd_count_q <= fwd_inc;
            if (i_passthru_en) begin
              latch_q <= 1'b1;
              state_q <= FORWARD;
            end else if (pt_cnt_q == PT_LAST) begin
              error_q <= 1'b1;
              state_q <= WAIT_RESET;
            end else begin
              pt_cnt_q <= pt_cnt_q + 1'b1;
            end
          end
        end
        FORWARD: begin
          if (gap) begin
            frame_count_q <= frame_count_q + 1'b1;
            state_q       <= CAPTURE;
            bit_count_q   <= '0;
            fwd_count_q   <= '0;
          end else if (!i_passthru_en) begin
            error_q <= 1'b1;
            state_q <= WAIT_RESET;
          end else if (i_bit_valid) begin
            fwd_count_q <= fwd_inc;
          end
        end
        default: state_q <= WAIT_RESET;
      endcase
    end
  end

  assign o_treset       = treset_q;
  assign o_valid        = valid_q;
  assign o_valid_strobe = valid_q;
  assign o_decode_bit   = decode_q;
  assign o_latch        = latch_q;
  assign o_error        = error_q;
  assign o_bit_count    = bit_count_q;
  assign o_fwd_count    = fwd_count_q;
  assign o_frame_count  = frame_count_q;
  assign o_frame_active = ((state_q == CAPTURE) && (bit_count_q != 5'd0)) ||
                          (state_q == WAIT_PT) || (state_q == FORWARD);

endmodule

// File: tb/tb_led_frame_sequencer.sv
// Scoreboard bench for led_frame_sequencer: stimulus queues expected pulses with their cycle,
// a negedge monitor pops and compares whenever a pulse output is seen.
module tb_led_frame_sequencer;
  localparam int RC = 8;
  localparam int PT = 4;
  localparam int CW = 16;

  logic          i_clk = 1'b0;
  logic          i_reset_n = 1'b0;
  logic          i_bit_valid = 1'b0;
  logic          i_bit = 1'b0;
  logic          i_line_idle = 1'b0;
  logic          i_passthru_en = 1'b0;
  logic          o_treset, o_valid, o_valid_strobe, o_decode_bit, o_latch, o_frame_active, o_error;
  logic [4:0]    o_bit_count;
  logic [CW-1:0] o_fwd_count, o_frame_count;

  led_frame_sequencer #(.RESET_CYCLES(RC), .LED_BITS(24), .PT_TIMEOUT(PT), .CNT_W(CW)) dut (
    .i_clk(i_clk), .i_reset_n(i_reset_n), .i_bit_valid(i_bit_valid), .i_bit(i_bit),
    .i_line_idle(i_line_idle), .i_passthru_en(i_passthru_en), .o_treset(o_treset),
    .o_valid(o_valid), .o_valid_strobe(o_valid_strobe), .o_decode_bit(o_decode_bit),
    .o_latch(o_latch), .o_frame_active(o_frame_active), .o_bit_count(o_bit_count),
    .o_fwd_count(o_fwd_count), .o_frame_count(o_frame_count), .o_error(o_error)
  );

  always #5 i_clk = ~i_clk;

  typedef struct {
    int   kind;   // 0 treset, 1 valid, 2 latch, 3 error
    logic b;
    int   cyc;
  } ev_t;

  ev_t   exp_q[$];
  int    cyc = 0;
  int    n_cmp = 0;
  int    n_bad = 0;
  string kn[4] = '{"treset", "valid", "latch", "error"};

  always @(posedge i_clk) cyc++;

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s @cycle %0d: got %0h, required %0h", nm, cyc, act, exp);
    end
  endtask

  task automatic push(input int kind, input logic b, input int at);
    ev_t e;
    e.kind = kind;
    e.b    = b;
    e.cyc  = at;
    exp_q.push_back(e);
  endtask

  always @(negedge i_clk) begin : monitor
    logic [3:0] seen;
    ev_t        e;
    seen = {o_error, o_latch, o_valid, o_treset};
    if (o_valid_strobe && !o_valid) begin
      n_cmp++;
      n_bad++;
      $display("FAIL strobe_without_valid @cycle %0d: got strobe=1, required 0", cyc);
    end
    for (int k = 0; k < 4; k++) begin
      if (seen[k]) begin
        if (exp_q.size() == 0) begin
          n_cmp++;
          n_bad++;
          $display("FAIL unexpected_%s @cycle %0d: got pulse, required none", kn[k], cyc);
        end else begin
          e = exp_q.pop_front();
          chk({"kind_", kn[k]}, k, e.kind);
          chk({"cycle_", kn[k]}, cyc, e.cyc);
          if (k == 1) begin
            chk("decode_bit", o_decode_bit, e.b);
            chk("valid_strobe", o_valid_strobe, 1);
          end
        end
      end
    end
  end

  task automatic tick();
    @(posedge i_clk);
    #1;
  endtask

  task automatic send(input logic b, input bit fwd);
    i_bit_valid = 1'b1;
    i_bit       = b;
    i_line_idle = 1'b0;
    if (fwd) push(1, b, cyc + 1);
    tick();
    i_bit_valid = 1'b0;
  endtask

  task automatic send_word(input logic [23:0] w, input bit fwd);
    for (int i = 23; i >= 0; i--) send(w[i], fwd);
  endtask

  // Treset (and optional error) appear RC cycles after the idle stretch starts.
  task automatic gap_evt(input bit err);
    i_line_idle = 1'b1;
    push(0, 1'b0, cyc + RC);
    if (err) push(3, 1'b0, cyc + RC);
    repeat (RC) tick();
    i_line_idle = 1'b0;
  endtask

  task automatic chk_all_zero(input string nm);
    chk({nm, "_pulses"}, {o_treset, o_valid, o_valid_strobe, o_decode_bit, o_latch, o_error, o_frame_active}, 0);
    chk({nm, "_bit_count"}, o_bit_count, 0);
    chk({nm, "_fwd_count"}, o_fwd_count, 0);
    chk({nm, "_frame_count"}, o_frame_count, 0);
  endtask

  initial begin : watchdog
    #200000;
    $display("FAIL watchdog: simulation exceeded time limit");
    $fatal(1, "watchdog expired");
  end

  initial begin : stim
    repeat (2) tick();
    chk_all_zero("reset");
    i_reset_n = 1'b1;
    repeat (2) tick();
    chk("post_reset_active", o_frame_active, 0);

    // WAIT_RESET ignores bits until the first gap.
    send(1'b1, 0); send(1'b0, 0); send(1'b1, 0);
    tick();
    chk("pre_gap_bit_count", o_bit_count, 0);
    gap_evt(0);
    chk("gap1_active", o_frame_active, 0);

    // Full frame, latch on passthrough.
    send_word(24'hA5C30F, 1);
    chk("frame1_bit_count", o_bit_count, 24);
    chk("frame1_active", o_frame_active, 1);
    i_passthru_en = 1'b1;
    push(2, 1'b0, cyc + 1);
    tick();

    // FORWARD: downstream bits counted, then gap closes the frame.
    for (int i = 0; i < 48; i++) send(i[0], 0);
    tick();
    chk("fwd_count_48", o_fwd_count, 48);
    chk("frame_count_pre", o_frame_count, 0);
    gap_evt(0);
    i_passthru_en = 1'b0;
    chk("frame_count_1", o_frame_count, 1);
    chk("frame1_end_bit_count", o_bit_count, 0);
    chk("frame1_end_fwd_count", o_fwd_count, 0);

    // Short frame: error, no frame count, next frame still latches.
    for (int i = 0; i < 10; i++) send(i[1], 1);
    chk("short_bit_count", o_bit_count, 10);
    gap_evt(1);
    chk("short_frame_count", o_frame_count, 1);
    chk("short_bit_count_clr", o_bit_count, 0);
    send_word(24'h123456, 1);
    i_passthru_en = 1'b1;
    push(2, 1'b0, cyc + 1);
    tick();
    chk("frame2_active", o_frame_active, 1);
    gap_evt(0);
    i_passthru_en = 1'b0;
    chk("frame_count_2", o_frame_count, 2);

    // Passthrough never arrives: timeout error, then back to WAIT_RESET.
    send_word(24'hFFFFFF, 1);
    push(3, 1'b0, cyc + PT);
    repeat (6) tick();
    chk("timeout_active", o_frame_active, 0);
    send(1'b1, 0); send(1'b0, 0);
    tick();
    chk("timeout_bit_count", o_bit_count, 24);
    chk("timeout_frame_count", o_frame_count, 2);

    // Reset mid-frame clears everything asynchronously.
    gap_evt(0);
    for (int i = 0; i < 12; i++) send(i[0], 1);
    tick();
    chk("mid_bit_count", o_bit_count, 12);
    i_reset_n = 1'b0;
    #1;
    chk_all_zero("async_reset");
    repeat (2) tick();
    i_reset_n = 1'b1;
    for (int i = 0; i < 5; i++) send(1'b1, 0);
    tick();
    chk("post_rst_bit_count", o_bit_count, 0);
    gap_evt(0);
    send(1'b1, 1);
    chk("rearm_bit_count", o_bit_count, 1);
    chk("rearm_active", o_frame_active, 1);

    repeat (3) tick();
    chk("scoreboard_empty", exp_q.size(), 0);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end
endmodule
